// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes follow RISC-V M-extension funct3 order.
package muldiv_unit_pkg;

  localparam int MULDIV_OP_WIDTH = 3;

  typedef enum logic [2:0] {
    MULDIV_OP_MUL    = 3'd0,
    MULDIV_OP_MULH   = 3'd1,
    MULDIV_OP_MULHSU = 3'd2,
    MULDIV_OP_MULHU  = 3'd3,
    MULDIV_OP_DIV    = 3'd4,
    MULDIV_OP_DIVU   = 3'd5,
    MULDIV_OP_REM    = 3'd6,
    MULDIV_OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Radix-2 iterative RISC-V M unit: shift-add multiply and restoring
// divide on magnitudes, sharing one XLEN+1-bit add/subtract step.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int OP_WIDTH = MULDIV_OP_WIDTH
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                io_req_valid,
  output logic                io_req_ready,
  input  logic [OP_WIDTH-1:0] io_req_op,
  input  logic [XLEN-1:0]     io_req_a,
  input  logic [XLEN-1:0]     io_req_b,
  input  logic                io_kill,
  output logic                io_resp_valid,
  input  logic                io_resp_ready,
  output logic [XLEN-1:0]     io_resp_data
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [OP_WIDTH-1:0] OP_MAX = OP_WIDTH'(7);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state, state_nx;
  muldiv_op_e      op_q;
  logic [XLEN-1:0] d_q, hi_q, lo_q, res_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q, nega_q;

  muldiv_op_e      op_in;
  logic            accept, is_div_in, op_undef;
  logic            sa_in, sb_in, div_zero, ovf, fast;
  logic [XLEN-1:0] abs_a, abs_b, fast_res;

  assign op_in     = muldiv_op_e'(io_req_op[2:0]);
  assign is_div_in = op_in[2];
  assign op_undef  = io_req_op > OP_MAX;

  assign sa_in = io_req_a[XLEN-1] &
                 (op_in == MULDIV_OP_MULH || op_in == MULDIV_OP_MULHSU ||
                  op_in == MULDIV_OP_DIV  || op_in == MULDIV_OP_REM);
  assign sb_in = io_req_b[XLEN-1] &
                 (op_in == MULDIV_OP_MULH || op_in == MULDIV_OP_DIV ||
                  op_in == MULDIV_OP_REM);

  assign abs_a = sa_in ? -io_req_a : io_req_a;
  assign abs_b = sb_in ? -io_req_b : io_req_b;

  assign div_zero = is_div_in && (io_req_b == '0);
  assign ovf = (op_in == MULDIV_OP_DIV || op_in == MULDIV_OP_REM) &&
               (io_req_a == MOST_NEG) && (io_req_b == '1);
  assign fast = op_undef || div_zero || ovf;

  // op[1] selects the remainder flavour of a divide
  always_comb begin
    fast_res = '0;
    unique case (1'b1)
      op_undef: fast_res = '0;
      div_zero: fast_res = op_in[1] ? io_req_a : '1;
      ovf:      fast_res = op_in[1] ? '0 : io_req_a;
      default:  fast_res = '0;
    endcase
  end

  assign accept = io_req_valid && (state == S_IDLE) && !io_kill;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (io_kill) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (io_req_valid) state_nx = fast ? S_DONE : S_CALC;
        S_CALC: if (cnt_q == CW'(XLEN)) state_nx = S_DONE;
        S_DONE: if (io_resp_ready) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  logic            is_div;
  logic [XLEN:0]   add_x, add_y;
  logic [XLEN+1:0] add_s;

  assign is_div = op_q[2];
  assign add_x  = is_div ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
  assign add_y  = (is_div || lo_q[0]) ? {1'b0, d_q} : '0;
  // bit XLEN+1 of a subtract is the no-borrow flag
  assign add_s  = {1'b0, add_x} + {1'b0, is_div ? ~add_y : add_y} +
                  {{(XLEN+1){1'b0}}, is_div};

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, res_calc;

  assign prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo_s  = neg_q ? -lo_q : lo_q;
  assign rem_s  = nega_q ? -hi_q : hi_q;

  always_comb begin
    res_calc = '0;
    unique case (op_q)
      MULDIV_OP_MUL:    res_calc = prod_s[XLEN-1:0];
      MULDIV_OP_MULH,
      MULDIV_OP_MULHSU,
      MULDIV_OP_MULHU:  res_calc = prod_s[2*XLEN-1:XLEN];
      MULDIV_OP_DIV,
      MULDIV_OP_DIVU:   res_calc = quo_s;
      default:          res_calc = rem_s;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= MULDIV_OP_MUL;
      d_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      nega_q <= 1'b0;
    end else if (accept) begin
      op_q   <= op_in;
      hi_q   <= '0;
      lo_q   <= is_div_in ? abs_a : abs_b;
      d_q    <= is_div_in ? abs_b : abs_a;
      cnt_q  <= '0;
      neg_q  <= sa_in ^ sb_in;
      nega_q <= sa_in;
      res_q  <= fast_res;
    end else if (state == S_CALC) begin
      if (cnt_q == CW'(XLEN)) begin
        res_q <= res_calc;
      end else begin
        cnt_q <= cnt_q + CW'(1);
        if (!is_div) begin
          hi_q <= add_s[XLEN:1];
          lo_q <= {add_s[0], lo_q[XLEN-1:1]};
        end else if (add_s[XLEN+1]) begin
          hi_q <= add_s[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_q <= add_x[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  assign io_req_ready  = (state == S_IDLE);
  assign io_resp_valid = (state == S_DONE);
  assign io_resp_data  = (state == S_DONE) ? res_q : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at XLEN=32.
// Latency is the index of the edge where resp_valid rises, accept edge = 0.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        kill;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  muldiv_unit dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .io_req_valid  (req_valid),
    .io_req_ready  (req_ready),
    .io_req_op     (req_op),
    .io_req_a      (req_a),
    .io_req_b      (req_b),
    .io_kill       (kill),
    .io_resp_valid (resp_valid),
    .io_resp_ready (resp_ready),
    .io_resp_data  (resp_data)
  );

  task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat,
                       output logic [31:0] data);
    @(negedge clock);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = -1; data = '0;
    for (int i = 0; i < 100; i++) begin
      if (resp_valid) begin
        lat = i; data = resp_data;
        break;
      end
      @(posedge clock); #1;
    end
    if (lat >= 0) begin
      resp_ready = 1'b1;
      @(posedge clock); #1;
      resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_op = '0;
    req_a = '0; req_b = '0; kill = 1'b0; resp_ready = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_hs: ready=%b valid=%b want 1/0", req_ready, resp_valid);
    end
    total++;
    if (resp_data !== 32'h0) begin
      bad++;
      $display("FAIL rst_data: got %h want 0", resp_data);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'h0) begin
      bad++;
      $display("FAIL post_rst: ready=%b valid=%b data=%h want 1/0/0",
               req_ready, resp_valid, resp_data);
    end
  endtask

  task automatic test_mul();
    int lat; logic [31:0] d;
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, lat, d);
    total++;
    if (lat !== 33) begin
      bad++; $display("FAIL mul_lat: got %0d want 33", lat);
    end
    total++;
    if (d !== 32'hFFFF_FFEB) begin
      bad++; $display("FAIL mul: got %h want ffffffeb", d);
    end
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, lat, d);
    total++;
    if (d !== 32'h4000_0000) begin
      bad++; $display("FAIL mulh: got %h want 40000000", d);
    end
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, d);
    total++;
    if (d !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL mulhu: got %h want fffffffe", d);
    end
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, lat, d);
    total++;
    if (d !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL mulhsu: got %h want ffffffff", d);
    end
    do_op(3'd1, 32'hFFFF_FFFF, 32'd5, lat, d);
    total++;
    if (d !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL mulh_neg: got %h want ffffffff", d);
    end
  endtask

  task automatic test_div();
    int lat; logic [31:0] d;
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, lat, d);
    total++;
    if (lat !== 33 || d !== 32'hFFFF_FFFD) begin
      bad++; $display("FAIL div: got %h lat %0d want fffffffd lat 33", d, lat);
    end
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, lat, d);
    total++;
    if (d !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL rem: got %h want ffffffff", d);
    end
    do_op(3'd5, 32'd100, 32'd7, lat, d);
    total++;
    if (d !== 32'd14) begin
      bad++; $display("FAIL divu: got %h want 0000000e", d);
    end
    do_op(3'd7, 32'd100, 32'd7, lat, d);
    total++;
    if (d !== 32'd2) begin
      bad++; $display("FAIL remu: got %h want 00000002", d);
    end
    do_op(3'd5, 32'd5, 32'd0, lat, d);
    total++;
    if (lat !== 0 || d !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL divu0: got %h lat %0d want ffffffff lat 0", d, lat);
    end
    do_op(3'd7, 32'd5, 32'd0, lat, d);
    total++;
    if (lat !== 0 || d !== 32'd5) begin
      bad++; $display("FAIL remu0: got %h lat %0d want 00000005 lat 0", d, lat);
    end
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, lat, d);
    total++;
    if (lat !== 0 || d !== 32'h8000_0000) begin
      bad++; $display("FAIL div_ovf: got %h lat %0d want 80000000 lat 0", d, lat);
    end
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, lat, d);
    total++;
    if (lat !== 0 || d !== 32'h0) begin
      bad++; $display("FAIL rem_ovf: got %h lat %0d want 0 lat 0", d, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat; int unstable; logic [31:0] d;
    @(negedge clock);
    req_valid = 1'b1; req_op = 3'd0; req_a = 32'd7; req_b = 32'hFFFF_FFFD;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      if (resp_valid) begin lat = i; break; end
      @(posedge clock); #1;
    end
    total++;
    if (lat < 0) begin
      bad++; $display("FAIL stall_wait: no resp_valid within 100 cycles");
    end
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid !== 1'b1 || resp_data !== 32'hFFFF_FFEB ||
          req_ready !== 1'b0)
        unstable++;
      @(posedge clock); #1;
    end
    total++;
    if (unstable !== 0) begin
      bad++; $display("FAIL stall_hold: %0d unstable cycles want 0", unstable);
    end
    @(negedge clock);
    resp_ready = 1'b1;
    req_valid = 1'b1; req_op = 3'd0; req_a = 32'd3; req_b = 32'd4;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'h0) begin
      bad++;
      $display("FAIL done_no_accept: ready=%b valid=%b data=%h want 1/0/0",
               req_ready, resp_valid, resp_data);
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    total++;
    if (req_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_accept: ready=%b want 0", req_ready);
    end
    lat = -1; d = '0;
    for (int i = 0; i < 100; i++) begin
      if (resp_valid) begin lat = i; d = resp_data; break; end
      @(posedge clock); #1;
    end
    total++;
    if (lat !== 33 || d !== 32'd12) begin
      bad++; $display("FAIL b2b_result: got %h lat %0d want 0000000c lat 33", d, lat);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_kill();
    int lat; int seen; logic [31:0] d;
    @(negedge clock);
    kill = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_a = 32'd9; req_b = 32'd9;
    @(posedge clock); #1;
    kill = 1'b0; req_valid = 1'b0;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL kill_prio: ready=%b want 1", req_ready);
    end
    @(negedge clock);
    req_valid = 1'b1; req_a = 32'd3; req_b = 32'd4;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    kill = 1'b1;
    @(posedge clock); #1;
    kill = 1'b0;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL kill_idle: ready=%b valid=%b want 1/0", req_ready, resp_valid);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) seen++;
      @(posedge clock); #1;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL kill_noresp: %0d valid cycles want 0", seen);
    end
    do_op(3'd0, 32'd3, 32'd4, lat, d);
    total++;
    if (d !== 32'd12) begin
      bad++; $display("FAIL kill_next: got %h want 0000000c", d);
    end
  endtask

  task automatic test_reset_mid();
    int lat; int seen; logic [31:0] d;
    @(negedge clock);
    req_valid = 1'b1; req_op = 3'd0; req_a = 32'd5; req_b = 32'd6;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (11) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid: ready=%b valid=%b data=%h want 1/0/0",
               req_ready, resp_valid, resp_data);
    end
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (resp_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL rst_noresp: %0d valid cycles want 0", seen);
    end
    do_op(3'd0, 32'd3, 32'd4, lat, d);
    total++;
    if (lat !== 33 || d !== 32'd12) begin
      bad++; $display("FAIL rst_next: got %h lat %0d want 0000000c lat 33", d, lat);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_kill();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
